// File: rtl/tail_light_pkg.sv
// tail_light_pkg: shared mode type and width helpers for the tail-light sequencer
package tail_light_pkg;
    typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZ} mode_t;
    function automatic int pos_w(input int lamps);
        return $clog2(lamps + 1);
    endfunction
    function automatic int cnt_w(input int prescale);
        return prescale > 1 ? $clog2(prescale) : 1;
    endfunction
endpackage

// File: rtl/step_timer.sv
// step_timer: prescale counter with synchronous clear, ticks on the last count
module step_timer
    import tail_light_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = cnt_w(PRESCALE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);
    logic [CNT_W-1:0] cnt;
    assign tick = cnt == LAST;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else cnt <= clr || tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/tail_light_seq.sv
// tail_light_seq: thermometer turn, hazard and brake sequencer for LAMPS lamps per side
module tail_light_seq
    import tail_light_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
    input  logic             brake,
    output logic [LAMPS-1:0] lamp_l,
    output logic [LAMPS-1:0] lamp_r
);
    localparam int POS_W = pos_w(LAMPS);
    localparam logic [POS_W-1:0] LAST = POS_W'(LAMPS);
    localparam logic [POS_W-1:0] ONE = POS_W'(1);
    localparam logic [LAMPS-1:0] ONES = '1;
    mode_t mode, mode_nxt;
    logic [POS_W-1:0] pos, pos_nxt;
    logic tick, haz_req, own;
    logic [LAMPS-1:0] therm, brk, flash, lamp_l_nxt, lamp_r_nxt;

    // held clear in IDLE so every entry starts a full step
    step_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk  (clk),
        .reset(reset),
        .clr  (mode == IDLE),
        .tick (tick)
    );

    always_comb begin
        haz_req = hazard | (left & right);
        own = mode == LEFT ? left : right;
        mode_nxt = mode;
        pos_nxt = pos;
        if (mode == IDLE) begin
            mode_nxt = haz_req ? HAZ : left ? LEFT : right ? RIGHT : IDLE;
            pos_nxt = haz_req | left | right ? ONE : '0;
        end else if (tick) begin
            if (mode != HAZ && haz_req) begin
                mode_nxt = HAZ;
                pos_nxt = ONE;
            end else if (pos == '0) begin
                mode_nxt = (mode == HAZ ? haz_req : own) ? mode : IDLE;
                pos_nxt = mode_nxt == IDLE ? '0 : ONE;
            end else
                pos_nxt = mode == HAZ || pos == LAST ? '0 : pos + 1'b1;
        end
        therm = ~(ONES << pos_nxt);
        brk = brake ? ONES : '0;
        flash = pos_nxt != '0 ? ONES : '0;
        lamp_l_nxt = mode_nxt == LEFT ? therm : mode_nxt == HAZ ? flash : brk;
        lamp_r_nxt = mode_nxt == RIGHT ? therm : mode_nxt == HAZ ? flash : brk;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            mode <= IDLE;
            pos <= '0;
            lamp_l <= '0;
            lamp_r <= '0;
        end else begin
            mode <= mode_nxt;
            pos <= pos_nxt;
            lamp_l <= lamp_l_nxt;
            lamp_r <= lamp_r_nxt;
        end
endmodule

// File: tb/tb_tail_light_seq.sv
// tb_tail_light_seq: directed checks of the default and a 5-lamp/prescale-4 sequencer
module tb_tail_light_seq;
    logic clk = 0, reset = 1, left = 0, right = 0, hazard = 0, brake = 0;
    logic [2:0] lamp_l, lamp_r;
    logic [4:0] lamp_l5, lamp_r5;
    logic [4:0] t5 [6] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b00000};
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    tail_light_seq dut (
        .clk(clk), .reset(reset), .left(left), .right(right),
        .hazard(hazard), .brake(brake), .lamp_l(lamp_l), .lamp_r(lamp_r)
    );

    tail_light_seq #(.LAMPS(5), .PRESCALE(4)) dut5 (
        .clk(clk), .reset(reset), .left(left), .right(right),
        .hazard(hazard), .brake(brake), .lamp_l(lamp_l5), .lamp_r(lamp_r5)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [2:0] el, input logic [2:0] er);
        @(posedge clk);
        #1;
        chk({tag, "_l"}, 8'(lamp_l), 8'(el));
        chk({tag, "_r"}, 8'(lamp_r), 8'(er));
    endtask

    initial begin
        #1 reset = 0;
        #1 chk("rst_async_l", 8'(lamp_l), 8'd0);
        repeat (3) cyc("rst", 3'b000, 3'b000);
        reset = 1;
        left = 1;
        cyc("l1", 3'b001, 3'b000);
        cyc("l2", 3'b011, 3'b000);
        cyc("l3", 3'b111, 3'b000);
        cyc("l0", 3'b000, 3'b000);
        cyc("l1b", 3'b001, 3'b000);
        left = 0;
        cyc("ld2", 3'b011, 3'b000);
        cyc("ld3", 3'b111, 3'b000);
        cyc("ld0", 3'b000, 3'b000);
        cyc("lidle", 3'b000, 3'b000);
        right = 1;
        cyc("r1", 3'b000, 3'b001);
        cyc("r2", 3'b000, 3'b011);
        right = 0;
        cyc("r3", 3'b000, 3'b111);
        cyc("r0", 3'b000, 3'b000);
        cyc("ridle", 3'b000, 3'b000);
        left = 1;
        right = 1;
        cyc("h1", 3'b111, 3'b111);
        cyc("h0", 3'b000, 3'b000);
        cyc("h1b", 3'b111, 3'b111);
        cyc("h0b", 3'b000, 3'b000);
        left = 0;
        right = 0;
        cyc("hidle", 3'b000, 3'b000);
        brake = 1;
        cyc("brk_idle", 3'b111, 3'b111);
        brake = 0;
        cyc("brk_off", 3'b000, 3'b000);
        brake = 1;
        left = 1;
        cyc("bl1", 3'b001, 3'b111);
        cyc("bl2", 3'b011, 3'b111);
        cyc("bl3", 3'b111, 3'b111);
        brake = 0;
        left = 0;
        cyc("bl0", 3'b000, 3'b000);
        cyc("blidle", 3'b000, 3'b000);
        left = 1;
        cyc("e1", 3'b001, 3'b000);
        cyc("e2", 3'b011, 3'b000);
        #3 reset = 0;
        #1 chk("async_l", 8'(lamp_l), 8'd0);
        chk("async_r", 8'(lamp_r), 8'd0);
        cyc("e_rst", 3'b000, 3'b000);
        reset = 1;
        cyc("e_re1", 3'b001, 3'b000);
        cyc("e_re2", 3'b011, 3'b000);
        left = 0;
        cyc("e_d3", 3'b111, 3'b000);
        cyc("e_d0", 3'b000, 3'b000);
        cyc("e_idle", 3'b000, 3'b000);

        reset = 0;
        @(posedge clk);
        #1 chk("p5_rst", 8'(lamp_l5), 8'd0);
        reset = 1;
        left = 1;
        for (int i = 0; i < 26; i++) begin
            @(posedge clk);
            #1 chk($sformatf("p5_l%0d", i), 8'(lamp_l5), 8'(t5[(i / 4) % 6]));
            if (i % 4 == 3) chk($sformatf("p5_r%0d", i), 8'(lamp_r5), 8'd0);
        end
        hazard = 1;
        for (int e = 27; e <= 32; e++) begin
            @(posedge clk);
            #1 chk($sformatf("p5_hl%0d", e), 8'(lamp_l5), e >= 29 ? 8'h1f : 8'h01);
            chk($sformatf("p5_hr%0d", e), 8'(lamp_r5), e >= 29 ? 8'h1f : 8'h00);
        end
        @(posedge clk);
        #1 chk("p5_h0_l", 8'(lamp_l5), 8'd0);
        chk("p5_h0_r", 8'(lamp_r5), 8'd0);
        hazard = 0;
        left = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
